// File: rtl/acc_frame_averager.sv
// Assembles an axis-tagged accelerometer stream into X,Y,Z frames and emits a
// floor-rounded boxcar average of 2^AVG_LOG2 frames with a valid/ready output.
module acc_frame_averager #(
    parameter int DATA_W   = 16,
    parameter int AVG_LOG2 = 2,
    parameter int ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_axis,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] acc_x,
    output logic signed [DATA_W-1:0] acc_y,
    output logic signed [DATA_W-1:0] acc_z,
    output logic [ERR_W-1:0]         err_cnt
);
    localparam int AW    = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [1:0] AX_X = 2'd0;
    localparam logic [1:0] AX_Y = 2'd1;
    localparam logic [1:0] AX_Z = 2'd2;
    localparam logic [1:0] AX_BAD = 2'd3;

    typedef enum logic [1:0] {WAIT_X, WAIT_Y, WAIT_Z} state_t;

    function automatic logic signed [AW-1:0] sext(input logic signed [DATA_W-1:0] v);
        logic signed [AW-1:0] r;
        r = v;
        return r;
    endfunction

    // Arithmetic shift gives floor division, i.e. rounding toward minus infinity.
    function automatic logic signed [DATA_W-1:0] avg_out(input logic signed [AW-1:0] s);
        logic signed [AW-1:0] sh;
        sh = s >>> AVG_LOG2;
        return sh[DATA_W-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic signed [DATA_W-1:0] xl_q, xl_d, yl_q, yl_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0]    sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
    logic signed [AW-1:0]    sum_x, sum_y, sum_z;
    logic signed [DATA_W-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
    logic                    ov_q, ov_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic                    beat, err_inc, complete;

    assign in_ready  = ~ov_q | out_ready;
    assign beat      = in_valid & in_ready;
    assign out_valid = ov_q;
    assign acc_x     = ox_q;
    assign acc_y     = oy_q;
    assign acc_z     = oz_q;
    assign err_cnt   = err_q;

    assign sum_x = sx_q + sext(xl_q);
    assign sum_y = sy_q + sext(yl_q);
    assign sum_z = sz_q + sext(in_data);

    always_comb begin
        state_d  = state_q;
        xl_d     = xl_q;
        yl_d     = yl_q;
        err_inc  = 1'b0;
        complete = 1'b0;
        if (beat) begin
            if (in_axis == AX_BAD) begin
                err_inc = 1'b1;
            end else begin
                case (state_q)
                    WAIT_X: begin
                        if (in_axis == AX_X) begin
                            xl_d    = in_data;
                            state_d = WAIT_Y;
                        end else begin
                            err_inc = 1'b1;
                        end
                    end
                    WAIT_Y: begin
                        if (in_axis == AX_Y) begin
                            yl_d    = in_data;
                            state_d = WAIT_Z;
                        end else if (in_axis == AX_X) begin
                            xl_d    = in_data;
                            err_inc = 1'b1;
                        end else begin
                            state_d = WAIT_X;
                            err_inc = 1'b1;
                        end
                    end
                    WAIT_Z: begin
                        if (in_axis == AX_Z) begin
                            complete = 1'b1;
                            state_d  = WAIT_X;
                        end else if (in_axis == AX_X) begin
                            xl_d    = in_data;
                            state_d = WAIT_Y;
                            err_inc = 1'b1;
                        end else begin
                            state_d = WAIT_X;
                            err_inc = 1'b1;
                        end
                    end
                    default: state_d = WAIT_X;
                endcase
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sx_d  = sx_q;
        sy_d  = sy_q;
        sz_d  = sz_q;
        ox_d  = ox_q;
        oy_d  = oy_q;
        oz_d  = oz_q;
        ov_d  = ov_q & ~out_ready;
        err_d = err_q;
        if (complete) begin
            if (cnt_q == LAST_FRAME) begin
                ox_d  = avg_out(sum_x);
                oy_d  = avg_out(sum_y);
                oz_d  = avg_out(sum_z);
                ov_d  = 1'b1;
                sx_d  = '0;
                sy_d  = '0;
                sz_d  = '0;
                cnt_d = '0;
            end else begin
                sx_d  = sum_x;
                sy_d  = sum_y;
                sz_d  = sum_z;
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (err_inc && err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_X;
            xl_q    <= '0;
            yl_q    <= '0;
            cnt_q   <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            sz_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            oz_q    <= '0;
            ov_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            cnt_q   <= cnt_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sz_q    <= sz_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            oz_q    <= oz_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_acc_frame_averager.sv
// Directed bench: a 4-frame averager with an 8-bit error count, and a
// pass-through instance with a 2-bit error count to exercise saturation.
module tb_acc_frame_averager;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]         a_in_axis;
    logic signed [15:0] a_in_data, a_acc_x, a_acc_y, a_acc_z;
    logic [7:0]         a_err;

    logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0]         b_in_axis;
    logic signed [15:0] b_in_data, b_acc_x, b_acc_y, b_acc_z;
    logic [1:0]         b_err;

    int tests = 0;
    int fails = 0;

    acc_frame_averager #(.DATA_W(16), .AVG_LOG2(2), .ERR_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_axis(a_in_axis), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .acc_x(a_acc_x), .acc_y(a_acc_y), .acc_z(a_acc_z), .err_cnt(a_err)
    );

    acc_frame_averager #(.DATA_W(16), .AVG_LOG2(0), .ERR_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_axis(b_in_axis), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .acc_x(b_acc_x), .acc_y(b_acc_y), .acc_z(b_acc_z), .err_cnt(b_err)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input int ax, input int d);
        a_in_valid = 1'b1;
        a_in_axis  = 2'(ax);
        a_in_data  = 16'(d);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic frame_a(input int x, input int y, input int z);
        send_a(0, x);
        send_a(1, y);
        send_a(2, z);
    endtask

    task automatic send_b(input int ax, input int d);
        b_in_valid = 1'b1;
        b_in_axis  = 2'(ax);
        b_in_data  = 16'(d);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_axis = 2'd0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_axis = 2'd0; b_in_data = '0; b_out_ready = 1'b1;
        idle();
        idle();
        rst = 1'b0;

        chk("rst_ov",    32'(a_out_valid), 0);
        chk("rst_x",     32'(a_acc_x), 0);
        chk("rst_err",   32'(a_err), 0);
        chk("rst_ready", 32'(a_in_ready), 1);
        chk("rst_b_ov",  32'(b_out_valid), 0);

        // Error counter saturation on the 2-bit instance.
        for (int i = 0; i < 3; i++) send_b(3, 0);
        chk("sat_err3", 32'(b_err), 3);
        for (int i = 0; i < 2; i++) send_b(3, 0);
        chk("sat_err_hold", 32'(b_err), 3);

        // Pass-through: one output per frame at latency 1.
        send_b(0, 3); send_b(1, -3); send_b(2, 7);
        chk("pt1_ov", 32'(b_out_valid), 1);
        chk("pt1_x",  32'(b_acc_x), 3);
        chk("pt1_y",  32'(b_acc_y), -3);
        chk("pt1_z",  32'(b_acc_z), 7);
        send_b(0, -5);
        chk("pt_drop", 32'(b_out_valid), 0);
        send_b(1, 9);
        send_b(2, -32768);
        chk("pt2_ov", 32'(b_out_valid), 1);
        chk("pt2_x",  32'(b_acc_x), -5);
        chk("pt2_y",  32'(b_acc_y), 9);
        chk("pt2_z",  32'(b_acc_z), -32768);
        chk("pt_err", 32'(b_err), 3);
        idle();

        // Clean 4-frame average.
        frame_a(4, -4, 100);
        frame_a(8, -8, 100);
        frame_a(12, -12, 100);
        chk("avg_early_ov", 32'(a_out_valid), 0);
        frame_a(16, -16, 100);
        chk("avg_ov", 32'(a_out_valid), 1);
        chk("avg_x",  32'(a_acc_x), 10);
        chk("avg_y",  32'(a_acc_y), -10);
        chk("avg_z",  32'(a_acc_z), 100);
        chk("avg_err", 32'(a_err), 0);
        idle();
        chk("avg_pulse", 32'(a_out_valid), 0);

        // Floor rounding: sum -7 -> -2, sum 7 -> 1.
        frame_a(-1, 1, 0);
        frame_a(-2, 2, 0);
        frame_a(-2, 2, 0);
        frame_a(-2, 2, 0);
        chk("rnd_ov", 32'(a_out_valid), 1);
        chk("rnd_neg", 32'(a_acc_x), -2);
        chk("rnd_pos", 32'(a_acc_y), 1);
        idle();

        // Framing errors: only (5,6,7) is accumulated.
        send_a(0, 1); send_a(2, 9); send_a(0, 2); send_a(1, 3);
        send_a(0, 5); send_a(1, 6); send_a(2, 7); send_a(3, 0);
        chk("frm_err", 32'(a_err), 3);
        chk("frm_ov",  32'(a_out_valid), 0);
        frame_a(5, 6, 7);
        frame_a(5, 6, 7);
        frame_a(5, 6, 7);
        chk("frm_avg_ov", 32'(a_out_valid), 1);
        chk("frm_x", 32'(a_acc_x), 5);
        chk("frm_y", 32'(a_acc_y), 6);
        chk("frm_z", 32'(a_acc_z), 7);
        idle();

        // Backpressure.
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) frame_a(20, -20, 3);
        chk("bp_ov",    32'(a_out_valid), 1);
        chk("bp_ready", 32'(a_in_ready), 0);
        chk("bp_x",     32'(a_acc_x), 20);
        send_a(0, 99);
        chk("bp_hold_ov", 32'(a_out_valid), 1);
        chk("bp_hold_x",  32'(a_acc_x), 20);
        chk("bp_hold_z",  32'(a_acc_z), 3);
        a_out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(a_in_ready), 1);
        idle();
        chk("bp_release", 32'(a_out_valid), 0);
        frame_a(1, 2, 3);
        frame_a(3, 2, 3);
        frame_a(1, 2, 3);
        frame_a(3, 2, 3);
        chk("bp_after_x", 32'(a_acc_x), 2);
        chk("bp_after_y", 32'(a_acc_y), 2);
        chk("bp_after_z", 32'(a_acc_z), 3);
        chk("bp_after_err", 32'(a_err), 3);
        idle();

        // Reset mid-average with a pending X.
        frame_a(100, 100, 100);
        frame_a(100, 100, 100);
        send_a(0, 50);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("mrst_ov",  32'(a_out_valid), 0);
        chk("mrst_x",   32'(a_acc_x), 0);
        chk("mrst_y",   32'(a_acc_y), 0);
        chk("mrst_z",   32'(a_acc_z), 0);
        chk("mrst_err", 32'(a_err), 0);
        for (int i = 0; i < 4; i++) frame_a(8, -8, 4);
        chk("mrst_avg_ov", 32'(a_out_valid), 1);
        chk("mrst_avg_x",  32'(a_acc_x), 8);
        chk("mrst_avg_y",  32'(a_acc_y), -8);
        chk("mrst_avg_z",  32'(a_acc_z), 4);
        chk("mrst_avg_err", 32'(a_err), 0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
